// File: rtl/dram_arbiter_pkg.sv
// Shared widths and FSM encodings for the DRAM arbiter and its round-robin picker.
package dram_arbiter_pkg;

  localparam int DRAM_ADDR_W = 17;
  localparam int DRAM_DATA_W = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;

endpackage

// File: rtl/dram_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker: a lone requester wins, a tie goes to
// the port that did not win last time.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic win_valid,
  output logic win_id
);

  // NOTE: every output gets a value on every path, so no latch is inferred.
  always_comb begin
    win_valid = req0 | req1;
    win_id    = 1'b0;
    if (req0 && req1) win_id = ~last;
    else if (req1)    win_id = 1'b1;
  end

endmodule

// File: rtl/dram_arbiter.sv
// Serialises single-byte read/write commands from two requesters onto one
// registered single-port DRAM and returns read data with a one-cycle valid pulse.
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int ADDR_W = DRAM_ADDR_W,
  parameter int DATA_W = DRAM_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_owner;
  logic             r_last;

  logic              w_win_valid;
  logic              w_win_id;
  logic              w_win_wr;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_wdata;

  rr_arb2 u_rr_arb2 (
    .req0      (req0),
    .req1      (req1),
    .last      (r_last),
    .win_valid (w_win_valid),
    .win_id    (w_win_id)
  );

  assign w_win_wr    = w_win_id ? wr1    : wr0;
  assign w_win_addr  = w_win_id ? addr1  : addr0;
  assign w_win_wdata = w_win_id ? wdata1 : wdata0;

  assign busy = (r_state != ST_IDLE);

  // NOTE: non-blocking assignments so every branch reads pre-edge register values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_owner     <= 1'b0;
      r_last      <= 1'b1;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      rvalid0     <= 1'b0;
      rvalid1     <= 1'b0;
      rdata       <= '0;
      mem_address <= '0;
      mem_data    <= '0;
      mem_wren    <= 1'b0;
    end else begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_win_valid) begin
            mem_address <= w_win_addr;
            mem_data    <= w_win_wdata;
            mem_wren    <= w_win_wr;
            gnt0        <= ~w_win_id;
            gnt1        <= w_win_id;
            r_owner     <= w_win_id;
            r_last      <= w_win_id;
            r_state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // The DRAM samples the command on this edge; a write is then complete.
          mem_wren <= 1'b0;
          if (mem_wren) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt   <= CNT_W'(RD_LAT - 1);
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            rdata   <= mem_q;
            rvalid0 <= ~r_owner;
            rvalid1 <= r_owner;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          mem_wren <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench: registered DRAM model plus dram_arbiter with RD_LAT=1.
`timescale 1ns/1ps
module tb_dram_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
  logic [16:0] addr0 = '0, addr1 = '0;
  logic [7:0]  wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, busy, mem_wren;
  logic [7:0]  rdata, mem_data, mem_q;
  logic [16:0] mem_address;

  int checks = 0;
  int failures = 0;
  int viol_wren = 0;
  int viol_excl = 0;

  logic [7:0] ram [0:(1<<17)-1];

  always #1 clock = ~clock;

  dram_arbiter #(.ADDR_W(17), .DATA_W(8), .RD_LAT(1)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .busy(busy),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
    .mem_q(mem_q)
  );

  // Registered single-port DRAM, read-before-write.
  always @(posedge clock) begin
    if (mem_wren) ram[mem_address] <= mem_data;
    mem_q <= ram[mem_address];
  end

  // Invariants: write enable only alongside a grant, never two grants or two valids.
  always @(negedge clock) begin
    if (!reset) begin
      if (mem_wren && !(gnt0 || gnt1)) viol_wren++;
      if ((gnt0 && gnt1) || (rvalid0 && rvalid1)) viol_excl++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic drive(input int p, input logic rq, input logic w,
                       input logic [16:0] a, input logic [7:0] d);
    if (p == 0) begin req0 = rq; wr0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = rq; wr1 = w; addr1 = a; wdata1 = d; end
  endtask

  function automatic logic gnt_of(input int p);
    return (p == 0) ? gnt0 : gnt1;
  endfunction

  function automatic logic rv_of(input int p);
    return (p == 0) ? rvalid0 : rvalid1;
  endfunction

  task automatic do_read(input int p, input logic [16:0] a, input logic [7:0] exp, input string tag);
    int n = 0;
    drive(p, 1'b1, 1'b0, a, 8'h00);
    do begin tick(); n++; end while (!gnt_of(p) && n < 10);
    check({tag, "_gnt"}, 32'(gnt_of(p)), 32'd1);
    drive(p, 1'b0, 1'b0, a, 8'h00);
    n = 0;
    do begin tick(); n++; end while (!rv_of(p) && n < 10);
    check({tag, "_rvalid"}, 32'(rv_of(p)), 32'd1);
    check({tag, "_rdata"}, 32'(rdata), 32'(exp));
  endtask

  initial begin
    int t_rv0, t_gnt1;
    logic [16:0] nxt_a [0:3];
    logic [7:0]  nxt_d [0:3];

    // 1. reset
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_gnt0", 32'(gnt0), 32'd0);
    check("rst_gnt1", 32'(gnt1), 32'd0);
    check("rst_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
    check("rst_wren", 32'(mem_wren), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_addr", 32'(mem_address), 32'd0);

    // 2. port 0 writes A5 to 5
    drive(0, 1'b1, 1'b1, 17'd5, 8'hA5);
    tick();
    check("w_gnt0", 32'(gnt0), 32'd1);
    check("w_gnt1", 32'(gnt1), 32'd0);
    check("w_wren", 32'(mem_wren), 32'd1);
    check("w_addr", 32'(mem_address), 32'd5);
    check("w_data", 32'(mem_data), 32'hA5);
    check("w_busy", 32'(busy), 32'd1);
    drive(0, 1'b0, 1'b0, 17'd0, 8'h00);
    tick();
    check("w_gnt0_pulse", 32'(gnt0), 32'd0);
    check("w_wren_pulse", 32'(mem_wren), 32'd0);
    check("w_busy_done", 32'(busy), 32'd0);

    // 3. port 1 reads 5
    drive(1, 1'b1, 1'b0, 17'd5, 8'h00);
    tick();
    check("r_gnt1", 32'(gnt1), 32'd1);
    check("r_wren", 32'(mem_wren), 32'd0);
    drive(1, 1'b0, 1'b0, 17'd0, 8'h00);
    tick();
    check("r_rv1_early", 32'(rvalid1), 32'd0);
    check("r_busy_wait", 32'(busy), 32'd1);
    tick();
    check("r_rv1", 32'(rvalid1), 32'd1);
    check("r_rv0", 32'(rvalid0), 32'd0);
    check("r_rdata", 32'(rdata), 32'hA5);
    tick();
    check("r_rv1_pulse", 32'(rvalid1), 32'd0);
    check("r_busy_done", 32'(busy), 32'd0);

    // 4. simultaneous requests: grants alternate 0,1,0,1
    nxt_a[0] = 17'd400; nxt_d[0] = 8'h11;
    nxt_a[1] = 17'd401; nxt_d[1] = 8'h22;
    nxt_a[2] = 17'd402; nxt_d[2] = 8'h33;
    nxt_a[3] = 17'd403; nxt_d[3] = 8'h44;
    drive(0, 1'b1, 1'b1, nxt_a[0], nxt_d[0]);
    drive(1, 1'b1, 1'b1, nxt_a[1], nxt_d[1]);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("tie%0d_gnt0", k), 32'(gnt0), 32'(k % 2 == 0));
      check($sformatf("tie%0d_gnt1", k), 32'(gnt1), 32'(k % 2 == 1));
      check($sformatf("tie%0d_addr", k), 32'(mem_address), 32'(nxt_a[k]));
      check($sformatf("tie%0d_data", k), 32'(mem_data), 32'(nxt_d[k]));
      if (k < 2) drive(k % 2, 1'b1, 1'b1, nxt_a[k + 2], nxt_d[k + 2]);
      else       drive(k % 2, 1'b0, 1'b0, 17'd0, 8'h00);
      tick();
      check($sformatf("tie%0d_gap", k), 32'({gnt1, gnt0}), 32'd0);
    end
    for (int k = 0; k < 4; k++)
      do_read(0, nxt_a[k], nxt_d[k], $sformatf("rb%0d", k));

    // 5. reset during WAIT drops the read
    drive(0, 1'b1, 1'b0, 17'd400, 8'h00);
    tick();
    check("rr_gnt0", 32'(gnt0), 32'd1);
    drive(0, 1'b0, 1'b0, 17'd0, 8'h00);
    tick();
    check("rr_in_wait", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rr_rv0_drop", 32'(rvalid0), 32'd0);
    check("rr_idle", 32'(busy), 32'd0);
    tick();
    check("rr_rv0_none", 32'(rvalid0), 32'd0);
    drive(0, 1'b1, 1'b1, 17'd500, 8'h55);
    drive(1, 1'b1, 1'b1, 17'd501, 8'h66);
    tick();
    check("rr_tie_gnt0", 32'(gnt0), 32'd1);
    check("rr_tie_gnt1", 32'(gnt1), 32'd0);
    drive(0, 1'b0, 1'b0, 17'd0, 8'h00);
    tick();
    tick();
    check("rr_next_gnt1", 32'(gnt1), 32'd1);
    drive(1, 1'b0, 1'b0, 17'd0, 8'h00);
    tick();

    // 6. req1 held across a port-0 read
    t_rv0 = -1; t_gnt1 = -1;
    drive(0, 1'b1, 1'b0, 17'd401, 8'h00);
    drive(1, 1'b1, 1'b1, 17'd502, 8'h77);
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (gnt0) drive(0, 1'b0, 1'b0, 17'd0, 8'h00);
      if (rvalid0 && t_rv0 < 0) begin
        t_rv0 = t;
        check("hold_rdata", 32'(rdata), 32'h22);
      end
      if (gnt1 && t_gnt1 < 0) begin
        t_gnt1 = t;
        drive(1, 1'b0, 1'b0, 17'd0, 8'h00);
      end
    end
    check("hold_rv0_time", 32'(t_rv0), 32'd3);
    check("hold_gnt1_time", 32'(t_gnt1), 32'd4);
    do_read(1, 17'd502, 8'h77, "hold_rb");
    do_read(0, 17'd500, 8'h55, "rr_rb0");
    do_read(1, 17'd501, 8'h66, "rr_rb1");

    check("wren_outside_access", 32'(viol_wren), 32'd0);
    check("exclusive_pulses", 32'(viol_excl), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
